mod_mul_stream: RTL and testbench
=================================

Name: mod_mul_stream

Overview:
- Parametrised, streaming modular multiplier; successor to the single-shot multiply-then-reduce unit.
- Computes r = f(a,b) mod P by MSB-first interleaved multiply-reduce, DIGIT bits per cycle.
- Has valid/ready handshakes on both sides, a pass-through tag, and three ops: MUL, SQR, MAC. MAC accumulates onto the last delivered result.
- Flags out-of-range operands.
- Sits between the point-arithmetic sequencer and the field-op result bus.

Parameters:
- P, 37, modulus; 2 <= P < 2^WIDTH.
- WIDTH, 128, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, multiplier bits consumed per RUN cycle; allowed values 1, 2, 4, 8.
- TAG_W, 8, width of the opaque tag carried with each request.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  2  00 MUL, 01 SQR, 10 MAC, 11 treated as MUL.
- in_a  in  WIDTH  first operand.
- in_b  in  WIDTH  second operand; ignored for SQR.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_r  out  WIDTH  result.
- out_tag  out  TAG_W  tag of this result.
- out_err  out  1  operand >= P detected; out_r forced to 0.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values:
  - State goes to IDLE.
  - in_ready=1 (combinational, IDLE only).
  - out_valid=0, out_r=0, out_tag=0, out_err=0.
  - Accumulator register accq=0.
  - Reset mid-operation aborts the job silently; no output is produced.
- State machine IDLE -> RUN -> [FIX] -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On accept, latch a, b (SQR: b:=a), op, tag.
  - Set err = (a>=P) || (b>=P).
  - Clear working acc=0 and digit counter cnt=0, then go to RUN.
- RUN, one cycle per digit:
  - Perform DIGIT iterations, MSB first. Per bit i: acc = 2*acc; if acc>=P then acc -= P; if b[i] then acc += a; if acc>=P then acc -= P.
  - Intermediates are WIDTH+1 bits; acc < P is invariant after every iteration.
  - cnt increments each cycle. After N = WIDTH/DIGIT cycles, go to FIX if op==MAC, else go to DONE.
- FIX (MAC only, 1 cycle): acc = acc + accq; if >= P, subtract P.
- DONE:
  - out_valid=1. out_r = err ? 0 : acc. out_tag = latched tag. out_err = err.
  - Outputs are stable while out_ready=0.
  - On consume: accq <= out_r, but only if err==0. Go to IDLE; out_valid drops next cycle.
- err is set at accept. The job still runs full latency so timing is data-independent.
- Latency, accept edge to out_valid high: N+1 cycles for MUL/SQR, N+2 for MAC.
  - WIDTH=128, DIGIT=4: 33 and 34 cycles.
- Throughput: one job per N+2 (MUL) or N+3 (MAC) cycles with out_ready=1.
- in_ready=0 in RUN/FIX/DONE. No accept in the same cycle a result is consumed.
- in_op=11 is executed as MUL; out_err stays 0.
- accq is cleared only by reset. A MAC as the first job after reset yields a*b mod P.

Decomposition:
- Package mod_mul_pkg:
  - op encoding constants OP_MUL, OP_SQR, OP_MAC.
  - State encoding IDLE/RUN/FIX/DONE.
  - Localparam helpers N = WIDTH/DIGIT and counter width $clog2(N+1).
- Sub-module mod_mul_digit_step: combinational; inputs acc, a, digit bits [DIGIT-1:0], P; output next acc. Performs the DIGIT unrolled double-add-reduce iterations.
- Top holds the FSM, operand/tag registers, accq and the handshakes.

Test Plan:
All scenarios use P=37, WIDTH=8, DIGIT=2, so N=4.
1. MUL a=5, b=9, tag=0x11, out_ready=1 -> out_valid exactly 5 cycles after accept; out_r=8, out_tag=0x11, out_err=0; in_ready low throughout.
2. SQR a=36, b=0x55 (ignored) -> out_r=1 (1296 mod 37).
3. MAC a=3, b=4 immediately after scenario 1 -> out_r=20 after 6 cycles. A second MAC a=1, b=17 -> out_r=0 (17+20=37).
4. MUL a=40, b=2 -> out_err=1, out_r=0, latency still 5. A following MAC a=1, b=1 uses unchanged accq and gives accq+1.
5. Backpressure: hold out_ready=0 for 7 cycles during scenario 1 -> out_r, out_tag and out_err stable; in_ready=0; exactly one consume on release.
6. Reset pulse in RUN cycle 2 of a MUL -> no out_valid ever. Next job MAC a=2, b=3 -> out_r=6, because accq was cleared.

Source files
------------

// File: rtl/mod_mul_pkg.sv
// mod_mul_pkg: op codes, FSM states and sizing helpers for the streaming modular multiplier
package mod_mul_pkg;
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SQR = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;
  function automatic int unsigned digits(input int unsigned w, input int unsigned d);
    return w / d;
  endfunction
  function automatic int unsigned cnt_bits(input int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/mod_mul_digit_step.sv
// mod_mul_digit_step: DIGIT unrolled MSB-first double/add/reduce iterations of acc*2^DIGIT + a*digit mod p
module mod_mul_digit_step #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DIGIT = 4
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [DIGIT-1:0] digit_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] acc_o
);
  logic [WIDTH:0] t, pp;
  assign pp = {1'b0, p_i};
  // one spare bit keeps 2*acc and acc+a exact while acc < p
  always_comb begin
    t = {1'b0, acc_i};
    for (int i = DIGIT - 1; i >= 0; i--) begin
      t = t << 1;
      t = (t >= pp) ? t - pp : t;
      t = digit_i[i] ? t + {1'b0, a_i} : t;
      t = (t >= pp) ? t - pp : t;
    end
    acc_o = t[WIDTH-1:0];
  end
endmodule

// File: rtl/mod_mul_stream.sv
// mod_mul_stream: streaming MUL/SQR/MAC modulo P, DIGIT multiplier bits per cycle, with
// valid/ready on both sides, a pass-through tag and an out-of-range operand flag
module mod_mul_stream
  import mod_mul_pkg::*;
#(
  parameter int unsigned     WIDTH = 128,
  parameter int unsigned     DIGIT = 4,
  parameter int unsigned     TAG_W = 8,
  parameter logic [WIDTH-1:0] P    = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  localparam int unsigned N  = digits(WIDTH, DIGIT);
  localparam int unsigned CW = cnt_bits(N);
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, accq_q, r_q, b_in, step, fix, fin;
  logic [WIDTH:0]   fix_sum;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [CW-1:0]    cnt_q;
  logic             err_q, valid_q, last;
  assign b_in    = (in_op == OP_SQR) ? in_a : in_b;
  assign fix_sum = {1'b0, acc_q} + {1'b0, accq_q};
  assign fix     = (fix_sum >= {1'b0, P}) ? WIDTH'(fix_sum - {1'b0, P}) : fix_sum[WIDTH-1:0];
  assign fin     = (state_q == FIX) ? fix : step;
  assign last    = (state_q == FIX) || (state_q == RUN && cnt_q == CW'(N - 1) && op_q != OP_MAC);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_r     = r_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;
  mod_mul_digit_step #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_step (
    .acc_i  (acc_q),
    .a_i    (a_q),
    .digit_i(b_q[WIDTH-1 -: DIGIT]),
    .p_i    (P),
    .acc_o  (step)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      accq_q  <= '0;
      r_q     <= '0;
      op_q    <= OP_MUL;
      tag_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= in_a;
          b_q     <= b_in;
          op_q    <= in_op;
          tag_q   <= in_tag;
          err_q   <= (in_a >= P) || (b_in >= P);
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          acc_q <= step;
          b_q   <= b_q << DIGIT;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= (op_q == OP_MAC) ? FIX : DONE;
        end
        FIX: begin
          acc_q   <= fix;
          state_q <= DONE;
        end
        DONE: if (out_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
          if (!err_q) accq_q <= r_q;
        end
      endcase
      if (last) begin
        valid_q <= 1'b1;
        r_q     <= err_q ? '0 : fin;
      end
    end
  end
endmodule

// File: tb/tb_mod_mul_stream.sv
// tb_mod_mul_stream: directed scenarios plus random jobs checked against an arithmetic model
module tb_mod_mul_stream;
  localparam int W = 8, D = 2, TW = 8, PM = 37, N = W / D;
  logic          clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic          in_ready, out_valid, out_err;
  logic [1:0]    in_op = 0;
  logic [W-1:0]  in_a = 0, in_b = 0, out_r;
  logic [TW-1:0] in_tag = 0, out_tag;
  typedef struct {int r; int tag; bit err; int lat;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, consumes = 0;
  int accq_m = 0, last_r = 0, last_err = 0, last_tag = 0, ready_mode = 1;
  bit seen = 0;

  mod_mul_stream #(.WIDTH(W), .DIGIT(D), .TAG_W(TW), .P(W'(PM))) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  initial forever begin
    @(posedge clk);
    #1 out_ready = (ready_mode == 2) ? 1'($urandom % 2) : (ready_mode == 1);
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      accq_m = 0;
      seen = 0;
    end else begin
      chk("in_ready", in_ready, q.size() == 0);
      if (q.size() != 0 && !seen && (out_valid || cyc - acc_cyc == q[0].lat)) begin
        chk("latency", out_valid ? cyc - acc_cyc : -1, q[0].lat);
        seen = 1;
      end
      if (q.size() == 0) chk("spurious_valid", out_valid, 0);
      else if (out_valid) begin
        chk("out_r", out_r, q[0].r);
        chk("out_tag", out_tag, q[0].tag);
        chk("out_err", out_err, q[0].err);
        if (out_ready) begin
          if (!q[0].err) accq_m = q[0].r;
          last_r = out_r;
          last_err = out_err;
          last_tag = out_tag;
          consumes++;
          q.pop_front();
          seen = 0;
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        int a, b;
        a = in_a;
        b = (in_op == 2'b01) ? a : int'(in_b);
        e.err = (a >= PM) || (b >= PM);
        e.r = e.err ? 0 : (in_op == 2'b10 ? (a * b + accq_m) % PM : (a * b) % PM);
        e.tag = in_tag;
        e.lat = (in_op == 2'b10) ? N + 2 : N + 1;
        q.push_back(e);
        acc_cyc = cyc;
        seen = 0;
      end
    end
  end

  task automatic send(input logic [1:0] op, input int a, input int b, input int tg);
    @(posedge clk);
    #1 in_valid = 1;
    in_op = op;
    in_a = W'(a);
    in_b = W'(b);
    in_tag = TW'(tg);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200 && q.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    chk("done_timeout", q.size(), 0);
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_r", out_r, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_err", out_err, 0);
    send(2'b00, 5, 9, 8'h11);
    wait_idle();
    chk("s1_r", last_r, 8);
    chk("s1_tag", last_tag, 8'h11);
    send(2'b10, 3, 4, 1);
    wait_idle();
    chk("s3_mac1", last_r, 20);
    send(2'b10, 1, 17, 2);
    wait_idle();
    chk("s3_mac2", last_r, 0);
    send(2'b01, 36, 8'h55, 3);
    wait_idle();
    chk("s2_sqr", last_r, 1);
    send(2'b00, 40, 2, 4);
    wait_idle();
    chk("s4_err", last_err, 1);
    chk("s4_r", last_r, 0);
    send(2'b10, 1, 1, 5);
    wait_idle();
    chk("s4_mac", last_r, 2);
    send(2'b11, 6, 7, 6);
    wait_idle();
    chk("op11_r", last_r, 5);
    chk("op11_err", last_err, 0);
    ready_mode = 0;
    c0 = consumes;
    send(2'b00, 5, 9, 8'h11);
    for (int t = 0; t < 50 && !out_valid; t++) begin
      @(negedge clk);
      #1;
    end
    chk("bp_valid", out_valid, 1);
    repeat (7) @(posedge clk);
    ready_mode = 1;
    wait_idle();
    repeat (3) @(posedge clk);
    chk("bp_consumes", consumes - c0, 1);
    chk("bp_r", last_r, 8);
    send(2'b00, 7, 7, 9);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    c0 = consumes;
    repeat (12) @(posedge clk);
    chk("abort_consumes", consumes - c0, 0);
    send(2'b10, 2, 3, 10);
    wait_idle();
    chk("s6_mac", last_r, 6);
    ready_mode = 2;
    for (int i = 0; i < 40; i++)
      send(2'($urandom % 4), int'($urandom % 46), int'($urandom % 46), int'($urandom % 256));
    ready_mode = 1;
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
